// File: rtl/npc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; owns pc, inst and the immediate select.
// Latency: 4 cycles per non-load, 5 per load, +1 per wait cycle; bus stalls time out into HALT.
// Backpressure: waits in FETCH/MEM for ifu_rvalid/lsu_rvalid; req outputs decode state only.
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic        lsu_req,
    input  logic        lsu_rvalid,
    input  logic [31:0] npc_in,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [1:0]  ext_type,
    output logic        rf_wen,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [1:0]  dec_ext;
    logic        dec_legal;
    logic        is_ebreak;

    // SYSTEM words other than ebreak fall into the illegal default.
    always_comb begin
        dec_ext   = 2'b00;
        dec_legal = 1'b1;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_ext = 2'b11;
            7'b0110111, 7'b0010111:             dec_ext = 2'b01;
            7'b1101111:                         dec_ext = 2'b10;
            7'b0110011:                         dec_ext = 2'b00;
            default:                            dec_legal = 1'b0;
        endcase
    end

    assign is_ebreak = (inst == EBREAK);

    // Gated with rst_n so no fetch is requested while reset is held.
    assign ifu_req = rst_n && (state == S_FETCH);
    assign lsu_req = (state == S_MEM);
    assign rf_wen  = (state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            inst     <= 32'h0;
            ext_type <= 2'b00;
            halt     <= 1'b0;
            err      <= 1'b0;
            tmo_cnt  <= 16'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (ifu_rvalid) begin
                        inst  <= ifu_rdata;
                        state <= S_DECODE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_HALT;
                        halt  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'h1;
                    end
                end
                S_DECODE: begin
                    if (is_ebreak) begin
                        ext_type <= 2'b00;
                        state    <= S_HALT;
                        halt     <= 1'b1;
                    end else if (!dec_legal) begin
                        ext_type <= 2'b00;
                        state    <= S_HALT;
                        halt     <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        ext_type <= dec_ext;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (inst[6:0] == OPC_LOAD) begin
                        tmo_cnt <= 16'h0;
                        state   <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (lsu_rvalid) begin
                        state <= S_WB;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_HALT;
                        halt  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'h1;
                    end
                end
                S_WB: begin
                    pc      <= npc_in;
                    tmo_cnt <= 16'h0;
                    state   <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                    halt  <= 1'b1;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Scoreboard bench for npc_seq_ctrl built with TIMEOUT=4 so wait-limit boundaries are cheap to reach.
module tb_npc_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req;
    logic        ifu_rvalid = 1'b0;
    logic [31:0] ifu_rdata = 32'h0;
    logic        lsu_req;
    logic        lsu_rvalid = 1'b0;
    logic [31:0] npc_in = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  ext_type;
    logic        rf_wen;
    logic        halt;
    logic        err;

    always #5 clk = ~clk;

    npc_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ifu_req    (ifu_req),
        .ifu_rvalid (ifu_rvalid),
        .ifu_rdata  (ifu_rdata),
        .lsu_req    (lsu_req),
        .lsu_rvalid (lsu_rvalid),
        .npc_in     (npc_in),
        .pc         (pc),
        .inst       (inst),
        .ext_type   (ext_type),
        .rf_wen     (rf_wen),
        .halt       (halt),
        .err        (err)
    );

    typedef struct {
        logic [1:0]  ext;
        logic [31:0] npc;
        int          cycles;
        int          mem_cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_ext(input logic [31:0] w);
        case (w[6:0])
            7'h13, 7'h03, 7'h67: return 2'b11;
            7'h37, 7'h17:        return 2'b01;
            7'h6F:               return 2'b10;
            default:             return 2'b00;
        endcase
    endfunction

    // Called at a negedge; leaves the bench just after the next negedge with the DUT in FETCH.
    task automatic do_reset();
        rst_n      = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_rvalid = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_ext", 32'(ext_type), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rf_wen", 32'(rf_wen), 32'h0);
        chk("rst_lsu_req", 32'(lsu_req), 32'h0);
        chk("rst_ifu_req", 32'(ifu_req), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ifu_req", 32'(ifu_req), 32'h1);
        exp_pc = RST_PC;
    endtask

    // fwait/lwait: number of wait cycles before the valid is returned.
    task automatic run_inst(input logic [31:0] word, input logic [31:0] npc,
                            input int fwait, input int lwait);
        exp_t e;
        exp_t g;
        bit   is_load;
        bit   done = 1'b0;
        int   cyc = 0;
        int   fcnt = 0;
        int   mcnt = 0;
        is_load      = (word[6:0] == 7'h03);
        e.ext        = exp_ext(word);
        e.npc        = npc;
        e.mem_cycles = is_load ? 1 + lwait : 0;
        e.cycles     = 4 + fwait + e.mem_cycles;
        sb.push_back(e);
        npc_in    = npc;
        ifu_rdata = word;
        while (!done && cyc < 60) begin
            cyc++;
            ifu_rvalid = ifu_req && (fcnt >= fwait);
            if (ifu_req) fcnt++;
            lsu_rvalid = lsu_req && (mcnt >= lwait);
            if (lsu_req) mcnt++;
            if (rf_wen) begin
                g = sb.pop_front();
                chk("wb_ext", 32'(ext_type), 32'(g.ext));
                chk("wb_pc", pc, exp_pc);
                chk("latency", 32'(cyc), 32'(g.cycles));
                chk("mem_cycles", 32'(mcnt), 32'(g.mem_cycles));
                chk("wb_halt", 32'(halt), 32'h0);
                done = 1'b1;
            end
            @(negedge clk);
        end
        chk("retired", 32'(done), 32'h1);
        chk("next_pc", pc, e.npc);
        chk("refetch", 32'(ifu_req), 32'h1);
        chk("rf_wen_width", 32'(rf_wen), 32'h0);
        exp_pc = npc;
    endtask

    task automatic run_halt(input logic [31:0] word, input logic exp_err);
        int cyc = 0;
        int busy = 0;
        ifu_rdata = word;
        while (!halt && cyc < 10) begin
            cyc++;
            ifu_rvalid = ifu_req;
            @(negedge clk);
        end
        ifu_rvalid = 1'b1;
        chk("halt", 32'(halt), 32'h1);
        chk("halt_err", 32'(err), 32'(exp_err));
        if (exp_err) chk("illegal_ext", 32'(ext_type), 32'h0);
        for (int i = 0; i < 20; i++) begin
            busy += int'(ifu_req) + int'(lsu_req) + int'(rf_wen);
            @(negedge clk);
        end
        chk("halt_quiet", 32'(busy), 32'h0);
        chk("halt_sticky", 32'(halt), 32'h1);
        ifu_rvalid = 1'b0;
    endtask

    // Starves either the fetch or the load data until the controller gives up.
    task automatic run_hang(input logic [31:0] word, input bit in_fetch);
        int cyc = 0;
        int waits = 0;
        ifu_rdata = word;
        while (!halt && cyc < 30) begin
            cyc++;
            ifu_rvalid = ifu_req && !in_fetch;
            lsu_rvalid = 1'b0;
            if (in_fetch ? ifu_req : lsu_req) waits++;
            @(negedge clk);
        end
        ifu_rvalid = 1'b0;
        chk(in_fetch ? "fetch_tmo_halt" : "mem_tmo_halt", 32'(halt), 32'h1);
        chk(in_fetch ? "fetch_tmo_err" : "mem_tmo_err", 32'(err), 32'h1);
        chk(in_fetch ? "fetch_tmo_wait" : "mem_tmo_wait", 32'(waits), 32'h4);
    endtask

    task automatic reset_in_mem();
        int cyc = 0;
        int wens = 0;
        ifu_rdata  = 32'h0000_2103;
        lsu_rvalid = 1'b0;
        while (!lsu_req && cyc < 10) begin
            cyc++;
            ifu_rvalid = ifu_req;
            @(negedge clk);
        end
        ifu_rvalid = 1'b0;
        chk("reached_mem", 32'(lsu_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_halt", 32'(halt), 32'h0);
        chk("mid_rst_lsu_req", 32'(lsu_req), 32'h0);
        for (int i = 0; i < 2; i++) begin
            wens += int'(rf_wen);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("mid_rst_no_wen", 32'(wens), 32'h0);
        chk("mid_rst_refetch", 32'(ifu_req), 32'h1);
        exp_pc = RST_PC;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        run_inst(32'h0010_0093, 32'h8000_0004, 0, 0);  // addi
        run_inst(32'h0000_10B7, 32'h8000_0008, 0, 0);  // lui
        run_inst(32'h0080_006F, 32'h8000_0010, 0, 0);  // jal
        run_inst(32'h0020_81B3, 32'h8000_0014, 0, 0);  // add
        run_inst(32'h0000_2103, 32'h8000_0018, 0, 3);  // lw, data on the last allowed MEM cycle
        run_inst(32'h0010_0093, 32'h8000_001C, 3, 0);  // addi, fetch on the last allowed cycle
        run_inst(32'h0000_80E7, 32'h8000_0100, 1, 0);  // jalr
        run_inst(32'h0000_0097, 32'h8000_0104, 0, 0);  // auipc
        reset_in_mem();
        run_inst(32'h0010_0093, 32'h8000_0004, 0, 0);
        run_halt(32'h0010_0073, 1'b0);                 // ebreak
        do_reset();
        run_halt(32'h0000_0000, 1'b1);                 // illegal opcode
        do_reset();
        run_halt(32'h0000_0073, 1'b1);                 // ecall: other SYSTEM word
        do_reset();
        run_hang(32'h0010_0093, 1'b1);
        do_reset();
        run_hang(32'h0000_2103, 1'b0);
        do_reset();
        run_inst(32'h0020_81B3, 32'h8000_0004, 2, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
